gpi_core: RTL and testbench

- RTIO general-purpose input core; the input-direction counterpart of the timestamped GPO path.
- Synchronizes an external input bus and detects edges per a programmable mode.
- Stamps each event with the RTIO counter and queues 128-bit {timestamp, data} records in a first-word-fall-through FIFO.
- The AXI interface module drains the FIFO via valid/ready; events lost to a full FIFO are reported on an error pulse with the dropped record.

---
 rtl/gpi_if.sv | 10 +
 rtl/gpi_core.sv | 108 ++++++++++
 tb/tb_gpi_core.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/gpi_if.sv
// Record stream from the GPI core to its consumer: a first-word-fall-through
// head record qualified by out_valid, accepted with out_ready.
interface gpi_if;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/gpi_core.sv
// RTIO general-purpose input core: synchronizes gpi_in, detects edges, and queues
// timestamped {counter, data} records in a FWFT FIFO with overflow reporting.
module gpi_core #(
  parameter int GPI_WIDTH  = 64,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [63:0]                 counter,
  input  logic [GPI_WIDTH-1:0]        gpi_in,
  input  logic                        capture_en,
  input  logic [1:0]                  edge_mode,
  gpi_if.master                       rec_bus,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow_error,
  output logic [127:0]                error_data
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_ANY  = 2'b11;

  logic [GPI_WIDTH-1:0] sync1, sync2, prev;
  logic [1:0]           prime_cnt;
  logic                 primed, cond, evt;
  logic                 full, pop, push, drop;
  logic [63:0]          data_ext;
  logic [127:0]         record;
  logic [127:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;

  // The prime counter keeps the cleared sync/prev chain from looking like an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1     <= '0;
      sync2     <= '0;
      prev      <= '0;
      prime_cnt <= '0;
    end else begin
      sync1 <= gpi_in;
      sync2 <= sync1;
      prev  <= sync2;
      if (prime_cnt != 2'd3)
        prime_cnt <= prime_cnt + 2'd1;
    end
  end

  assign primed = (prime_cnt == 2'd3);

  always_comb begin
    cond = 1'b0;
    case (edge_mode)
      MODE_OFF:  cond = 1'b0;
      MODE_RISE: cond = |(sync2 & ~prev);
      MODE_FALL: cond = |(~sync2 & prev);
      MODE_ANY:  cond = |(sync2 ^ prev);
      default:   cond = 1'b0;
    endcase
  end

  assign evt = cond & capture_en & primed;

  always_comb begin
    data_ext                 = '0;
    data_ext[GPI_WIDTH-1:0]  = sync2;
  end

  assign record = {counter, data_ext};

  assign full               = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign rec_bus.out_valid  = (fifo_count != '0);
  assign rec_bus.out_data   = rec_bus.out_valid ? mem[rd_ptr] : '0;
  assign pop                = rec_bus.out_valid & rec_bus.out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push               = evt & (~full | pop);
  assign drop               = evt & full & ~pop;

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= record;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_count     <= '0;
      overflow_error <= 1'b0;
      error_data     <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
      overflow_error <= drop;
      if (drop)
        error_data <= record;
    end
  end
endmodule

// File: tb/tb_gpi_core.sv
// Directed bench for gpi_core: table-driven edge-mode vectors plus hand-written
// sequences for latency, ordering, overflow, full-with-pop and reset.
module tb_gpi_core;
  localparam int GW = 64;
  localparam int FD = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [63:0]   counter;
  logic [GW-1:0] gpi_in;
  logic          capture_en;
  logic [1:0]    edge_mode;
  logic [4:0]    fifo_count;
  logic          overflow_error;
  logic [127:0]  error_data;

  int checks = 0;
  int errors = 0;

  gpi_if bus ();

  gpi_core #(.GPI_WIDTH(GW), .FIFO_DEPTH(FD)) dut (
    .clk            (clk),
    .reset          (reset),
    .counter        (counter),
    .gpi_in         (gpi_in),
    .capture_en     (capture_en),
    .edge_mode      (edge_mode),
    .rec_bus        (bus),
    .fifo_count     (fifo_count),
    .overflow_error (overflow_error),
    .error_data     (error_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic        en;
    logic [63:0] from_v;
    logic [63:0] to_v;
    logic        exp_rec;
  } vec_t;

  vec_t         vecs [12];
  logic [127:0] q [$];

  // The counter advances once per clock; the value sampled at an edge is the one
  // present just before that tick.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      counter = counter + 64'd1;
    end
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  initial begin
    vecs[0]  = '{2'b01, 1'b1, 64'h0,  64'h1,  1'b1};
    vecs[1]  = '{2'b01, 1'b1, 64'h1,  64'h0,  1'b0};
    vecs[2]  = '{2'b10, 1'b1, 64'h1,  64'h0,  1'b1};
    vecs[3]  = '{2'b10, 1'b1, 64'h0,  64'h1,  1'b0};
    vecs[4]  = '{2'b11, 1'b1, 64'h5,  64'hA,  1'b1};
    vecs[5]  = '{2'b11, 1'b1, 64'hF0, 64'hF0, 1'b0};
    vecs[6]  = '{2'b00, 1'b1, 64'h0,  64'hFF, 1'b0};
    vecs[7]  = '{2'b01, 1'b0, 64'h0,  64'h1,  1'b0};
    vecs[8]  = '{2'b01, 1'b1, 64'h3,  64'h5,  1'b1};
    vecs[9]  = '{2'b10, 1'b1, 64'h3,  64'h5,  1'b1};
    vecs[10] = '{2'b01, 1'b1, 64'h0,  64'h8000_0000_0000_0000, 1'b1};
    vecs[11] = '{2'b10, 1'b1, 64'h6,  64'h7,  1'b0};

    // Reset state, with gpi_in already high so the guard is exercised on release
    reset = 1'b1; gpi_in = 64'h1; edge_mode = 2'b01; capture_en = 1'b1;
    bus.out_ready = 1'b0; counter = 64'd0;
    tick(2);
    chk("rst_valid", 128'(bus.out_valid), 128'd0);
    chk("rst_count", 128'(fifo_count), 128'd0);
    chk("rst_ovf", 128'(overflow_error), 128'd0);
    chk("rst_err", error_data, 128'd0);
    chk("rst_data", bus.out_data, 128'd0);
    reset = 1'b0;
    tick(5);
    chk("guard_count", 128'(fifo_count), 128'd0);
    gpi_in = 64'h0;
    tick(4);
    chk("fall_in_rise_mode", 128'(fifo_count), 128'd0);

    // First record latency and timestamp
    counter = 64'd98; gpi_in = 64'h1;
    tick(2);
    chk("latency_k1_valid", 128'(bus.out_valid), 128'd0);
    tick(1);
    chk("latency_k2_valid", 128'(bus.out_valid), 128'd1);
    chk("first_record", bus.out_data, {64'd100, 64'h1});
    chk("first_count", 128'(fifo_count), 128'd1);
    bus.out_ready = 1'b1; tick(1); bus.out_ready = 1'b0;

    // Four toggles of bit 3 in any-change mode, then ordered drain
    edge_mode = 2'b00; gpi_in = 64'h0; tick(4);
    edge_mode = 2'b11; q.delete();
    for (int i = 0; i < 4; i++) begin
      gpi_in = (i % 2 == 0) ? 64'h8 : 64'h0;
      q.push_back({counter + 64'd2, gpi_in});
      tick(3);
    end
    chk("toggle_count", 128'(fifo_count), 128'd4);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("toggle_head%0d", i), bus.out_data, q[i]);
      chk($sformatf("toggle_cnt%0d", i), 128'(fifo_count), 128'(4 - i));
      tick(1);
    end
    bus.out_ready = 1'b0;
    chk("toggle_empty_count", 128'(fifo_count), 128'd0);
    chk("toggle_empty_valid", 128'(bus.out_valid), 128'd0);

    // Edge-mode table
    for (int v = 0; v < 12; v++) begin
      edge_mode = 2'b00; capture_en = 1'b1; gpi_in = vecs[v].from_v;
      tick(4);
      edge_mode = vecs[v].mode; capture_en = vecs[v].en; gpi_in = vecs[v].to_v;
      q.delete();
      q.push_back({counter + 64'd2, vecs[v].to_v});
      tick(3);
      chk($sformatf("vec%0d_count", v), 128'(fifo_count), 128'(vecs[v].exp_rec));
      if (vecs[v].exp_rec)
        chk($sformatf("vec%0d_data", v), bus.out_data, q[0]);
      bus.out_ready = 1'b1; tick(1); bus.out_ready = 1'b0;
      edge_mode = 2'b00; capture_en = 1'b1;
    end

    // Overflow: 17 events into a 16-deep FIFO
    gpi_in = 64'h0; tick(4);
    edge_mode = 2'b11; q.delete();
    for (int j = 1; j <= 17; j++) begin
      gpi_in = 64'(j % 2);
      q.push_back({counter + 64'd2, 64'(j % 2)});
      tick(1);
    end
    tick(1);
    chk("ovf_pre_pulse", 128'(overflow_error), 128'd0);
    chk("ovf_pre_count", 128'(fifo_count), 128'd16);
    tick(1);
    chk("ovf_pulse", 128'(overflow_error), 128'd1);
    chk("ovf_err_data", error_data, q[16]);
    chk("ovf_count", 128'(fifo_count), 128'd16);
    chk("ovf_head", bus.out_data, q[0]);
    tick(1);
    chk("ovf_pulse_end", 128'(overflow_error), 128'd0);
    chk("ovf_err_hold", error_data, q[16]);

    // Full FIFO, event coinciding with a pop
    void'(q.pop_back());
    gpi_in = 64'h0;
    q.push_back({counter + 64'd2, 64'h0});
    tick(2);
    bus.out_ready = 1'b1; tick(1); bus.out_ready = 1'b0;
    void'(q.pop_front());
    chk("fullpop_ovf", 128'(overflow_error), 128'd0);
    chk("fullpop_count", 128'(fifo_count), 128'd16);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("fullpop_drain%0d", i), bus.out_data, q[i]);
      tick(1);
    end
    bus.out_ready = 1'b0;
    chk("fullpop_empty", 128'(fifo_count), 128'd0);

    // capture_en gating and falling-only mode
    edge_mode = 2'b01; capture_en = 1'b0; gpi_in = 64'h1; tick(3);
    chk("en_off", 128'(fifo_count), 128'd0);
    capture_en = 1'b1; tick(3);
    chk("en_late", 128'(fifo_count), 128'd0);
    edge_mode = 2'b10; capture_en = 1'b0; gpi_in = 64'h0; tick(3);
    capture_en = 1'b1; gpi_in = 64'h1; tick(3);
    chk("fall_mode_rise", 128'(fifo_count), 128'd0);
    gpi_in = 64'h0;
    q.delete();
    q.push_back({counter + 64'd2, 64'h0});
    tick(3);
    chk("fall_mode_fall_cnt", 128'(fifo_count), 128'd1);
    chk("fall_mode_fall_data", bus.out_data, q[0]);

    // Reset with records queued
    bus.out_ready = 1'b1; tick(1); bus.out_ready = 1'b0;
    edge_mode = 2'b11;
    for (int i = 0; i < 5; i++) begin
      gpi_in = (i % 2 == 0) ? 64'h1 : 64'h0;
      tick(2);
    end
    tick(3);
    chk("pre_reset_count", 128'(fifo_count), 128'd5);
    reset = 1'b1; tick(1);
    chk("midrst_valid", 128'(bus.out_valid), 128'd0);
    chk("midrst_count", 128'(fifo_count), 128'd0);
    chk("midrst_err", error_data, 128'd0);
    chk("midrst_data", bus.out_data, 128'd0);
    chk("midrst_ovf", 128'(overflow_error), 128'd0);
    reset = 1'b0; tick(6);
    chk("post_reset_guard", 128'(fifo_count), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
